// File: rtl/iob_axi_bridge.sv
// iob_axi_bridge: converts single native requests (valid/ready, wstrb selects
// write vs read) into single-beat AXI4 transactions, one outstanding at a time.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for valid; captures address/wdata/wstrb on acceptance
// WR    | awvalid/wvalid up, each dropped on its own handshake
// BRESP | bready up, waiting for the write response
// RD    | arvalid up until arready
// RDATA | rready up, waiting for the read beat
// DONE  | transaction finished; native ready is registered out next cycle
module iob_axi_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    valid,
  input  logic [ADDR_W-1:0]       address,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ready,
  output logic                    err,

  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [1:0]              m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,

  output logic [AXI_ID_W-1:0]     m_axi_arid,
  output logic [AXI_ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [1:0]              m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,

  input  logic [AXI_ID_W-1:0]     m_axi_rid,
  input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CP_W  = (ADDR_W < AXI_ADDR_W) ? ADDR_W : AXI_ADDR_W;

  typedef enum logic [2:0] {IDLE, WR, BRESP, RD, RDATA, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W/8-1:0]     wstrb_q;
  logic [AXI_ADDR_W-1:0]   axi_addr;

  logic                    awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
  logic                    ready_d, err_d;
  logic [DATA_W-1:0]       rdata_d;

  logic                    accept;
  logic                    wr_done;

  // IDs, rlast and the response IDs carry nothing for single-beat, in-order use
  logic                    unused_in;
  assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

  // ready still high means the master has not yet seen completion; its valid
  // may still be up from the finished request, so it must not be re-accepted
  assign accept  = (state_q == IDLE) && valid && !ready;
  assign wr_done = (!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready);

  // Word-aligned AXI address, zero-extended or truncated to AXI_ADDR_W
  always_comb begin
    axi_addr              = '0;
    axi_addr[CP_W-1:0]    = addr_q[CP_W-1:0];
    axi_addr[OFF_W-1:0]   = '0;
  end

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = axi_addr;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(OFF_W);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'd0;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = axi_addr;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(OFF_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'd0;

  // State and registered handshake/native outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_rready  <= 1'b0;
      ready         <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
    end else begin
      state_q       <= state_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_rready  <= rready_d;
      ready         <= ready_d;
      err           <= err_d;
      rdata         <= rdata_d;
    end
  end

  // Request capture when a new transaction is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= address;
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (|wstrb) ? WR : RD;
      WR:      if (wr_done) state_d = BRESP;
      BRESP:   if (m_axi_bvalid) state_d = DONE;
      RD:      if (m_axi_arready) state_d = RDATA;
      RDATA:   if (m_axi_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    awvalid_d = m_axi_awvalid;
    wvalid_d  = m_axi_wvalid;
    arvalid_d = m_axi_arvalid;
    bready_d  = m_axi_bready;
    rready_d  = m_axi_rready;
    ready_d   = 1'b0;
    err_d     = err;
    rdata_d   = rdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          awvalid_d = |wstrb;
          wvalid_d  = |wstrb;
          arvalid_d = ~|wstrb;
        end
      end
      WR: begin
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (wr_done)       bready_d  = 1'b1;
      end
      BRESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
        end
      end
      RD: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = m_axi_rdata;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
        end
      end
      DONE:    ready_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_iob_axi_bridge.sv
// Directed bench for iob_axi_bridge with a small behavioural AXI slave.
module tb_iob_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  logic [0:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [1:0]  m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [0:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [0:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [1:0]  m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [0:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  iob_axi_bridge dut (
    .clk(clk), .rst(rst),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // slave knobs
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
  bit          b_hold = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  logic [31:0] rdata_val = '0;

  // slave / monitor state
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit aw_got = 0, w_got = 0, ar_got = 0, b_taken = 0, r_taken = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, ready_cnt = 0;
  int split_cnt = 0, bready_early = 0, revalid_cnt = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb, cap_awcache;
  logic        cap_wlast;
  logic [7:0]  cap_awlen, cap_arlen;
  logic [2:0]  cap_awsize, cap_arsize;
  logic [1:0]  cap_awburst;

  // posedge monitor: handshake bookkeeping from pre-edge values
  initial forever begin
    @(posedge clk);
    if (m_axi_awvalid && !m_axi_wvalid) split_cnt++;
    if ((m_axi_awvalid && aw_got) || (m_axi_wvalid && w_got)) revalid_cnt++;
    if (m_axi_bready && !m_axi_bvalid && !(aw_got && w_got)) bready_early++;
    if (ready) ready_cnt++;
    if (m_axi_awvalid && m_axi_awready) begin
      aw_hs++; aw_got = 1;
      cap_awaddr = m_axi_awaddr; cap_awlen = m_axi_awlen; cap_awsize = m_axi_awsize;
      cap_awburst = m_axi_awburst; cap_awcache = m_axi_awcache;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_hs++; w_got = 1;
      cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; cap_wlast = m_axi_wlast;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      ar_hs++; ar_got = 1;
      cap_araddr = m_axi_araddr; cap_arlen = m_axi_arlen; cap_arsize = m_axi_arsize;
    end
    if (m_axi_bvalid && m_axi_bready) b_taken = 1;
    if (m_axi_rvalid && m_axi_rready) r_taken = 1;
  end

  // negedge slave: drives all AXI inputs of the DUT
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
    m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rid = 0; m_axi_rlast = 1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_taken = 0; r_taken = 0;
      end else begin
        if (m_axi_awvalid && !m_axi_awready) begin
          if (aw_cnt >= aw_lat) m_axi_awready = 1; else aw_cnt++;
        end else begin m_axi_awready = 0; aw_cnt = 0; end
        if (m_axi_wvalid && !m_axi_wready) begin
          if (w_cnt >= w_lat) m_axi_wready = 1; else w_cnt++;
        end else begin m_axi_wready = 0; w_cnt = 0; end
        if (m_axi_arvalid && !m_axi_arready) begin
          if (ar_cnt >= ar_lat) m_axi_arready = 1; else ar_cnt++;
        end else begin m_axi_arready = 0; ar_cnt = 0; end
        if (m_axi_bvalid) begin
          if (b_taken) begin m_axi_bvalid = 0; b_taken = 0; end
        end else if (aw_got && w_got && !b_hold) begin
          m_axi_bvalid = 1; m_axi_bresp = bresp_val; aw_got = 0; w_got = 0;
        end
        if (m_axi_rvalid) begin
          if (r_taken) begin m_axi_rvalid = 0; r_taken = 0; end
        end else if (ar_got) begin
          if (r_cnt >= r_lat) begin
            m_axi_rvalid = 1; m_axi_rdata = rdata_val; m_axi_rresp = rresp_val;
            ar_got = 0; r_cnt = 0;
          end else r_cnt++;
        end
      end
    end
  end

  logic [31:0] rd_seen;
  int          lat, axi_cyc;

  // One native request; lat = cycle (after the sampling edge) where ready is seen.
  // valid stays up through the edge closing the ready cycle, as a registered master would.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int lat_o, output int axi_o);
    lat_o = -1; axi_o = -1;
    @(negedge clk);
    valid = 1; address = a; wdata = d; wstrb = s;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (axi_o < 0 && (m_axi_awvalid || m_axi_arvalid)) axi_o = c;
      if (ready) begin lat_o = c; rd_seen = rdata; break; end
    end
    if (lat_o < 0) check_val("req_timeout", 64'(lat_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    valid = 0;
  endtask

  int aw0, w0, ar0, rc0;
  bit got_bready;

  initial begin
    rst = 0; valid = 0; address = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk); #1;
    check_val("rst_ready",   ready, 0);
    check_val("rst_err",     err, 0);
    check_val("rst_rdata",   rdata, 0);
    check_val("rst_awvalid", m_axi_awvalid, 0);
    check_val("rst_wvalid",  m_axi_wvalid, 0);
    check_val("rst_arvalid", m_axi_arvalid, 0);
    check_val("rst_bready",  m_axi_bready, 0);
    check_val("rst_rready",  m_axi_rready, 0);
    @(negedge clk); rst = 1;
    repeat (2) @(posedge clk);

    // basic write, also exercises the valid-held-after-ready guard
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; rc0 = ready_cnt;
    do_req(32'h104, 32'hDEADBEEF, 4'hF, lat, axi_cyc);
    repeat (6) @(posedge clk); #1;
    check_val("wr_lat",     64'(lat), 64'd4);
    check_val("wr_aw_cyc",  64'(axi_cyc), 64'd1);
    check_val("wr_awaddr",  cap_awaddr, 32'h104);
    check_val("wr_wdata",   cap_wdata, 32'hDEADBEEF);
    check_val("wr_wstrb",   cap_wstrb, 4'hF);
    check_val("wr_wlast",   cap_wlast, 1);
    check_val("wr_awlen",   cap_awlen, 0);
    check_val("wr_awsize",  cap_awsize, 3'd2);
    check_val("wr_awburst", cap_awburst, 2'b01);
    check_val("wr_awcache", cap_awcache, 4'b0011);
    check_val("wr_err",     err, 0);
    check_val("wr_one_aw",  64'(aw_hs - aw0), 64'd1);
    check_val("wr_one_w",   64'(w_hs - w0), 64'd1);
    check_val("wr_no_ar",   64'(ar_hs - ar0), 64'd0);
    check_val("wr_one_rdy", 64'(ready_cnt - rc0), 64'd1);

    // read with 3-cycle data delay, unaligned address
    r_lat = 3; rdata_val = 32'h12345678; rc0 = ready_cnt; ar0 = ar_hs;
    do_req(32'h203, 32'h0, 4'h0, lat, axi_cyc);
    repeat (4) @(posedge clk); #1;
    check_val("rd_araddr",  cap_araddr, 32'h200);
    check_val("rd_arlen",   cap_arlen, 0);
    check_val("rd_arsize",  cap_arsize, 3'd2);
    check_val("rd_lat",     64'(lat), 64'd7);
    check_val("rd_data",    rd_seen, 32'h12345678);
    check_val("rd_one_rdy", 64'(ready_cnt - rc0), 64'd1);
    check_val("rd_one_ar",  64'(ar_hs - ar0), 64'd1);
    r_lat = 0;

    // write with awready 2 cycles after wready, partial strobes
    aw_lat = 2; rc0 = ready_cnt; split_cnt = 0; bready_early = 0; revalid_cnt = 0;
    do_req(32'h40, 32'hA5A50F0F, 4'h3, lat, axi_cyc);
    repeat (4) @(posedge clk); #1;
    check_val("skew_lat",     64'(lat), 64'd6);
    check_val("skew_split",   64'(split_cnt), 64'd2);
    check_val("skew_revalid", 64'(revalid_cnt), 64'd0);
    check_val("skew_bready",  64'(bready_early), 64'd0);
    check_val("skew_one_rdy", 64'(ready_cnt - rc0), 64'd1);
    check_val("skew_awaddr",  cap_awaddr, 32'h40);
    check_val("skew_wstrb",   cap_wstrb, 4'h3);
    check_val("skew_rd_hold", rdata, 32'h12345678);
    aw_lat = 0;

    // read with SLVERR sets sticky err
    rresp_val = 2'b10; rdata_val = 32'hCAFEF00D;
    do_req(32'h10, 32'h0, 4'h0, lat, axi_cyc);
    repeat (2) @(posedge clk); #1;
    check_val("slverr_lat",  64'(lat), 64'd4);
    check_val("slverr_err",  err, 1);
    check_val("slverr_data", rdata, 32'hCAFEF00D);
    rresp_val = 2'b00;
    do_req(32'h20, 32'h55, 4'hF, lat, axi_cyc);
    repeat (2) @(posedge clk); #1;
    check_val("okwr_lat",    64'(lat), 64'd4);
    check_val("okwr_sticky", err, 1);

    // reset while waiting in BRESP
    b_hold = 1; rc0 = ready_cnt; got_bready = 0;
    @(negedge clk);
    valid = 1; address = 32'h80; wdata = 32'h11; wstrb = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_axi_bready) begin got_bready = 1; break; end
    end
    check_val("rstmid_in_bresp", got_bready, 1);
    #2 rst = 0;
    #1;
    check_val("rstmid_bready",  m_axi_bready, 0);
    check_val("rstmid_awvalid", m_axi_awvalid, 0);
    check_val("rstmid_arvalid", m_axi_arvalid, 0);
    check_val("rstmid_ready",   ready, 0);
    check_val("rstmid_err",     err, 0);
    check_val("rstmid_rdata",   rdata, 0);
    valid = 0;
    repeat (2) @(posedge clk); #1;
    check_val("rstmid_no_rdy", 64'(ready_cnt - rc0), 64'd0);
    b_hold = 0;
    @(negedge clk); rst = 1;
    repeat (2) @(posedge clk);
    rdata_val = 32'h0BADCAFE; ar0 = ar_hs;
    do_req(32'h304, 32'h0, 4'h0, lat, axi_cyc);
    repeat (2) @(posedge clk); #1;
    check_val("post_rst_lat",    64'(lat), 64'd4);
    check_val("post_rst_araddr", cap_araddr, 32'h304);
    check_val("post_rst_data",   rd_seen, 32'h0BADCAFE);
    check_val("post_rst_err",    err, 0);
    check_val("post_rst_one_ar", 64'(ar_hs - ar0), 64'd1);
    check_val("post_rst_one_rdy", 64'(ready_cnt - rc0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
